// File: rtl/clk_meter.sv
// -----------------------------------------------------------------------------
// clk_meter
//
// Measures a slow square wave (such as a divided clock) in clk cycles. The
// input is brought into the clk domain, and the meter counts clk cycles from
// one rising edge to the next (period) and from a rising edge to the following
// falling edge (high time). Each completed measurement is held for a consumer
// until it is acknowledged.
//
// Parameters:
//   CNT_W    - width of the cycle counters and of the measurement outputs
//   TIMEOUT  - cycles without a rising edge before the input counts as lost
//              (2 <= TIMEOUT <= 2**CNT_W-1)
//
// Ports:
//   clk        in   system clock, all state on the rising edge
//   rst        in   synchronous reset, active low
//   sig_in     in   measured square wave, asynchronous to clk
//   meas_ack   in   consumer accepts the held measurement
//   period     out  clk cycles from rising edge to rising edge
//   high_time  out  clk cycles from rising edge to falling edge
//   meas_valid out  a measurement is held, stays high until acknowledged
//   overrun    out  sticky: a measurement was dropped while one was held
//   stalled    out  no rising edge seen for TIMEOUT cycles
// -----------------------------------------------------------------------------
module clk_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             meas_ack,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             overrun,
  output logic             stalled
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  // sync_reg[0] is the first flop; [1] and [2] feed the edge detector.
  // All stages reset to 1 so a high input at reset release is not an edge.
  logic [2:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] hcap_reg;
  state_t           state_reg;

  logic rise;
  logic fall;
  logic timed_out;
  logic meas_done;

  assign rise      = sync_reg[1] & ~sync_reg[2];
  assign fall      = ~sync_reg[1] & sync_reg[2];
  assign timed_out = (cnt_reg == TIMEOUT_C) && !rise;
  // A measurement only completes once a full high phase has been observed.
  assign meas_done = (state_reg == RUN) && rise;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_reg   <= 3'b111;
      cnt_reg    <= '0;
      hcap_reg   <= '0;
      state_reg  <= IDLE;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      overrun    <= 1'b0;
      stalled    <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[1:0], sig_in};

      // Cycle counter restarts at 1 on every rise so that at the next rise it
      // holds the exact number of edges between the two rising samples.
      if (rise) begin
        cnt_reg <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (cnt_reg != TIMEOUT_C) begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      if (fall) begin
        hcap_reg <= cnt_reg;
      end

      case (state_reg)
        IDLE: begin
          if (rise) begin
            state_reg <= ARMED;
            stalled   <= 1'b0;
          end
        end
        ARMED: begin
          if (timed_out) begin
            state_reg <= IDLE;
            stalled   <= 1'b1;
          end else if (fall) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (timed_out) begin
            state_reg <= IDLE;
            stalled   <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Output handshake. A new measurement may replace the held one only if
      // the held one is free or being acknowledged on this very edge.
      if (meas_done) begin
        if (!meas_valid || meas_ack) begin
          period     <= cnt_reg;
          high_time  <= hcap_reg;
          meas_valid <= 1'b1;
          overrun    <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (meas_ack && meas_valid) begin
        meas_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_meter.sv
// -----------------------------------------------------------------------------
// tb_clk_meter
//
// Drives clk_meter with directed and randomized square waves and acknowledge
// patterns. A reference model works on sampled-edge timestamps: it records
// the sample index of each rising and falling input transition, derives
// period and high time as differences of those indices, and applies the
// results to the outputs two edges later together with the handshake rules.
// -----------------------------------------------------------------------------
module tb_clk_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 20;

  logic             clk      = 1'b0;
  logic             rst      = 1'b0;
  logic             sig_in   = 1'b1;
  logic             meas_ack = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             overrun;
  logic             stalled;

  clk_meter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .meas_ack   (meas_ack),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .overrun    (overrun),
    .stalled    (stalled)
  );

  always #5 clk = ~clk;

  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (timestamps of sampled edges, 2-edge output latency)
  // ---------------------------------------------------------------------------
  int  n_idx;        // number of sampling edges since reset release
  bit  prev_s;       // previously sampled input level
  int  mode;         // 0: waiting for first rise, 1: rise seen, 2: rise+fall seen
  int  r0, f0;       // sample index of last rise / last fall
  bit  p_meas [2];
  int  p_per  [2];
  int  p_ht   [2];
  bit  p_set  [2];
  bit  p_clr  [2];
  int  m_period, m_high;
  bit  m_valid, m_over, m_stall;
  bit  model_on = 1'b0;

  always @(posedge clk) begin : model_blk
    bit rs, fs;
    if (!rst) begin
      model_on = 1'b1;
      n_idx = 0; prev_s = 1'b1; mode = 0; r0 = 0; f0 = 0;
      m_period = 0; m_high = 0; m_valid = 0; m_over = 0; m_stall = 0;
      for (int i = 0; i < 2; i++) begin
        p_meas[i] = 0; p_per[i] = 0; p_ht[i] = 0; p_set[i] = 0; p_clr[i] = 0;
      end
    end else begin
      // events from the sample two edges ago take effect now
      if (p_meas[1]) begin
        if (!m_valid || meas_ack) begin
          m_period = p_per[1];
          m_high   = p_ht[1];
          m_valid  = 1;
          m_over   = 0;
          $display("meas period %0d high %0d ack %0b", m_period, m_high, meas_ack);
        end else begin
          m_over = 1;
          $display("meas dropped period %0d high %0d", p_per[1], p_ht[1]);
        end
      end else if (meas_ack && m_valid) begin
        m_valid = 0;
        m_over  = 0;
      end
      if (p_set[1]) m_stall = 1;
      if (p_clr[1]) m_stall = 0;

      p_meas[1] = p_meas[0]; p_per[1] = p_per[0]; p_ht[1] = p_ht[0];
      p_set[1]  = p_set[0];  p_clr[1] = p_clr[0];
      p_meas[0] = 0; p_set[0] = 0; p_clr[0] = 0;

      n_idx++;
      rs = sig_in && !prev_s;
      fs = !sig_in && prev_s;
      prev_s = sig_in;
      if (mode == 0) begin
        if (rs) begin
          mode = 1; r0 = n_idx; p_clr[0] = 1;
        end
      end else if (rs) begin
        if (mode == 2) begin
          p_meas[0] = 1; p_per[0] = n_idx - r0; p_ht[0] = f0 - r0;
        end
        r0 = n_idx;
      end else if (n_idx - r0 >= TIMEOUT) begin
        mode = 0; p_set[0] = 1;
      end else if (fs) begin
        if (mode == 1) mode = 2;
        f0 = n_idx;
      end
      if (fs && mode == 0) f0 = n_idx;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check_val("period",     32'(period),     32'(m_period));
      check_val("high_time",  32'(high_time),  32'(m_high));
      check_val("meas_valid", 32'(meas_valid), 32'(m_valid));
      check_val("overrun",    32'(overrun),    32'(m_over));
      check_val("stalled",    32'(stalled),    32'(m_stall));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // ack_mode: 0 low, 1 high, 2 follow meas_valid, 3 random, 4 on completion
  int ack_mode = 0;

  task automatic cyc(input bit s);
    @(negedge clk);
    sig_in = s;
    case (ack_mode)
      0:       meas_ack = 1'b0;
      1:       meas_ack = 1'b1;
      2:       meas_ack = meas_valid;
      3:       meas_ack = 1'($urandom_range(0, 1));
      default: meas_ack = p_meas[1];
    endcase
  endtask

  task automatic wave(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) cyc(1'b1);
      for (int i = 0; i < lo; i++) cyc(1'b0);
    end
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) cyc(1'b1);
    rst = 1'b1;

    // divider toggling every 5 cycles, ack held high
    ack_mode = 1; wave(5, 5, 10);
    // asymmetric input, ack one cycle after valid
    ack_mode = 2; wave(3, 7, 8);
    // random shapes and random acks
    ack_mode = 3;
    for (int i = 0; i < 30; i++) wave($urandom_range(2, 8), $urandom_range(2, 8), 1);

    // overrun: no ack for several periods, then an ack pulse
    ack_mode = 0; wave(5, 5, 3);
    check_val("overrun_set", 32'(overrun), 32'd1);
    ack_mode = 1; cyc(1'b1);
    ack_mode = 0; repeat (4) cyc(1'b1);
    check_val("overrun_clr", 32'(overrun), 32'd0);
    wave(5, 5, 2);

    // stall: input stops low, then restarts
    ack_mode = 0; wave(5, 5, 2);
    repeat (40) cyc(1'b0);
    check_val("stall_set", 32'(stalled), 32'd1);
    wave(5, 5, 4);

    // reset mid-period while a measurement is held
    ack_mode = 0; wave(5, 5, 3);
    cyc(1'b1); cyc(1'b1);
    rst = 1'b0; cyc(1'b1); rst = 1'b1;
    repeat (15) cyc(1'b1);
    // reset with input held high through release
    rst = 1'b0; cyc(1'b1); rst = 1'b1;
    repeat (10) cyc(1'b1);
    check_val("no_meas_high", 32'(meas_valid), 32'd0);
    wave(4, 6, 4);

    // acknowledge exactly on the completing edge
    ack_mode = 4; wave(5, 5, 6);
    for (int i = 0; i < 20; i++) begin
      ack_mode = (i % 2 == 0) ? 4 : 3;
      wave($urandom_range(2, 9), $urandom_range(2, 9), 2);
    end

    ack_mode = 0;
    repeat (5) cyc(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
